// File: rtl/seq_signed_mult_4bit.sv
// Sequential signed multiplier: sign/magnitude split, shift-add over WIDTH cycles, valid/ready on both sides.
// Optional MAC accumulator is compiled in when MULT_ACC_EN is defined.
module seq_signed_mult_4bit #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ACC_W = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   input  logic                 acc_clr,
   output logic [ACC_W-1:0]     acc_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     mag_a_q, mag_a_d;
   logic [WIDTH-1:0]     mag_b_q, mag_b_d;
   logic                 sgn_q, sgn_d;
   logic [2*WIDTH-1:0]   part_q, part_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [2*WIDTH-1:0]   addend;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign p         = p_q;

   assign addend = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      sgn_d   = sgn_q;
      part_d  = part_q;
      p_d     = p_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Negating the most negative value wraps to itself, which reads as +2^(WIDTH-1) unsigned.
               mag_a_d = a[WIDTH-1] ? (~a + 1'b1) : a;
               mag_b_d = b[WIDTH-1] ? (~b + 1'b1) : b;
               sgn_d   = a[WIDTH-1] ^ b[WIDTH-1];
               part_d  = '0;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               p_d     = sgn_q ? (~part_q + 1'b1) : part_q;
               state_d = S_DONE;
            end else begin
               if (mag_b_q[0]) begin
                  part_d = part_q + addend;
               end
               mag_b_d = mag_b_q >> 1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         sgn_q   <= 1'b0;
         part_q  <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         sgn_q   <= sgn_d;
         part_q  <= part_d;
         p_q     <= p_d;
      end
   end

`ifdef MULT_ACC_EN
   logic [ACC_W-1:0] acc_q, acc_d;

   // Clear wins over a coincident handshake; that product is dropped from the sum.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr) begin
         acc_d = '0;
      end else if (out_valid && out_ready) begin
         acc_d = acc_q + {{(ACC_W-2*WIDTH){p_q[2*WIDTH-1]}}, p_q};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_out = acc_q;
`else
   logic unused_acc_clr;
   assign unused_acc_clr = acc_clr;
   assign acc_out        = '0;
`endif

endmodule
